// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the PC and keeps at most one request outstanding to a variable-latency
// instruction memory. A fetched word can be parked across hazard stalls, and a
// fetch that is still in flight when a redirect arrives is drained and dropped.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus4_if,
    output logic        if_valid,
    output logic        if_busy
);

    // FETCH   : request at addr_reg is pending or answered this cycle
    // HOLD    : word parked in hold_instr while the pipeline is stalled
    // DISCARD : a stale request is still in flight; its reply is dropped
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_reg, pc_nxt;
    logic [31:0] addr_reg, addr_nxt;
    logic [31:0] hold_instr, hold_nxt;

    logic [31:0] redirect_tgt;
    logic [31:0] seq_addr;
    logic        fetch_hit;

    // Redirect targets are word aligned.
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    // Sequential successor; wraps naturally at 2^32.
    assign seq_addr     = addr_reg + 32'd4;
    // The pending fetch completes in this cycle (possibly zero-wait).
    assign fetch_hit    = (state == FETCH) && imem_rvalid;

    // Output decode. Everything is forced quiet while reset is held so the
    // memory never sees a request before the stage is running.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = addr_reg;
        pc_if       = addr_reg;
        pc_plus4_if = seq_addr;
        if_valid    = 1'b0;
        if_busy     = 1'b0;
        instr_if    = NOP_INSTR;
        if (!rst) begin
            imem_req = (state != HOLD);
            if_busy  = ((state == FETCH) && !imem_rvalid) || (state == DISCARD);
            // A redirect this cycle kills whatever would have been presented.
            if (!redirect_valid) begin
                if (fetch_hit) begin
                    if_valid = 1'b1;
                    instr_if = imem_rdata;
                end else if (state == HOLD) begin
                    if_valid = 1'b1;
                    instr_if = hold_instr;
                end
            end
        end
    end

    // Next-state logic. Redirect beats everything, including stall_if.
    // addr_reg only moves when no request is pending, so imem_addr stays
    // stable for the whole life of a request.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_reg;
        addr_nxt  = addr_reg;
        hold_nxt  = hold_instr;
        if (redirect_valid) begin
            pc_nxt = redirect_tgt;
            if ((state == FETCH || state == DISCARD) && !imem_rvalid) begin
                // Request still in flight: keep its address, drain it first.
                state_nxt = DISCARD;
            end else begin
                // Nothing pending (or it completes now and is dropped).
                state_nxt = FETCH;
                addr_nxt  = redirect_tgt;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_rvalid) begin
                        if (stall_if) begin
                            hold_nxt  = imem_rdata;
                            state_nxt = HOLD;
                        end else begin
                            addr_nxt = seq_addr;
                            pc_nxt   = seq_addr;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_if) begin
                        addr_nxt  = seq_addr;
                        pc_nxt    = seq_addr;
                        state_nxt = FETCH;
                    end
                end
                DISCARD: begin
                    // Stale reply arrives: restart at the redirect target.
                    if (imem_rvalid) begin
                        addr_nxt  = pc_reg;
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    // State and address registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc_reg     <= RESET_PC;
            addr_reg   <= RESET_PC;
            hold_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            pc_reg     <= pc_nxt;
            addr_reg   <= addr_nxt;
            hold_instr <= hold_nxt;
        end
    end

endmodule
